// File: rtl/pipe_pkg.sv
// Shared EX-stage definitions: datapath widths, ALUOp/funct encodings, ALU op enum,
// and bit positions inside the ex/mem/wb control bundles.
package pipe_pkg;

  localparam int WORD_SIZE = 32;
  localparam int REG_SIZE  = 5;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ADD2  = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT,
    ALU_ZERO
  } alu_op_e;

  localparam int EX_REGDST   = 3;
  localparam int EX_ALUSRC   = 2;
  localparam int EX_ALUOP_HI = 1;
  localparam int EX_ALUOP_LO = 0;

  localparam int MEM_READ   = 2;
  localparam int MEM_WRITE  = 1;
  localparam int MEM_BRANCH = 0;

  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/execute_unit_if.sv
// ID/EX -> EX/MEM bundle; master drives the instruction slot, slave is the EX stage.
// Forwarding sources exist only when FORWARDING_EN is defined.
interface execute_unit_if;
  import pipe_pkg::*;

  logic                 in_valid;
  logic                 stall;
  logic                 flush;
  logic [3:0]           ex_ctrl_in;
  logic [2:0]           mem_ctrl_in;
  logic [1:0]           wb_ctrl_in;
  logic [WORD_SIZE-1:0] pc_in;
  logic [WORD_SIZE-1:0] read_data1;
  logic [WORD_SIZE-1:0] read_data2;
  logic [WORD_SIZE-1:0] imm_in;
  logic [REG_SIZE-1:0]  rt_in;
  logic [REG_SIZE-1:0]  rd_in;
`ifdef FORWARDING_EN
  logic [REG_SIZE-1:0]  rs_in;
  logic                 wb_reg_write;
  logic [REG_SIZE-1:0]  wb_reg;
  logic [WORD_SIZE-1:0] wb_data;
`endif

  logic                 out_valid;
  logic [2:0]           mem_ctrl_out;
  logic [1:0]           wb_ctrl_out;
  logic [WORD_SIZE-1:0] alu_result;
  logic [WORD_SIZE-1:0] store_data;
  logic [WORD_SIZE-1:0] branch_target;
  logic                 zero;
  logic [REG_SIZE-1:0]  write_reg;
  logic                 illegal_funct;

  modport master (
`ifdef FORWARDING_EN
    output rs_in, wb_reg_write, wb_reg, wb_data,
`endif
    output in_valid, stall, flush, ex_ctrl_in, mem_ctrl_in, wb_ctrl_in,
    output pc_in, read_data1, read_data2, imm_in, rt_in, rd_in,
    input  out_valid, mem_ctrl_out, wb_ctrl_out, alu_result, store_data,
    input  branch_target, zero, write_reg, illegal_funct
  );

  modport slave (
`ifdef FORWARDING_EN
    input  rs_in, wb_reg_write, wb_reg, wb_data,
`endif
    input  in_valid, stall, flush, ex_ctrl_in, mem_ctrl_in, wb_ctrl_in,
    input  pc_in, read_data1, read_data2, imm_in, rt_in, rd_in,
    output out_valid, mem_ctrl_out, wb_ctrl_out, alu_result, store_data,
    output branch_target, zero, write_reg, illegal_funct
  );

endinterface

// File: rtl/alu_core.sv
// Combinational ALU: add/sub wrap modulo 2^WORD_SIZE, slt is signed, ALU_ZERO yields 0.
import pipe_pkg::*;

module alu_core (
  input  alu_op_e              i_op,
  input  logic [WORD_SIZE-1:0] i_a,
  input  logic [WORD_SIZE-1:0] i_b,
  output logic [WORD_SIZE-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD: o_result = i_a + i_b;
      ALU_SUB: o_result = i_a - i_b;
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_SLT: o_result = {{(WORD_SIZE-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_unit.sv
// MIPS EX stage: ALU decode/compute, branch target, dest select, registered into EX/MEM (1 cycle).
// flush beats stall beats load; FORWARDING_EN adds EX/MEM and WB operand bypass.
import pipe_pkg::*;

module execute_unit (
  input  logic         clk,
  input  logic         rst,
  execute_unit_if.slave i_ex
);

  logic [1:0]           w_aluop;
  logic [5:0]           w_funct;
  alu_op_e              w_op;
  logic                 w_illegal;
  logic [WORD_SIZE-1:0] w_op_a;
  logic [WORD_SIZE-1:0] w_rt_val;
  logic [WORD_SIZE-1:0] w_op_b;
  logic [WORD_SIZE-1:0] w_result;
  logic [WORD_SIZE-1:0] w_target;
  logic [REG_SIZE-1:0]  w_dest;

  logic                 r_out_valid;
  logic [2:0]           r_mem_ctrl;
  logic [1:0]           r_wb_ctrl;
  logic [WORD_SIZE-1:0] r_alu_result;
  logic [WORD_SIZE-1:0] r_store_data;
  logic [WORD_SIZE-1:0] r_branch_target;
  logic                 r_zero;
  logic [REG_SIZE-1:0]  r_write_reg;
  logic                 r_illegal;

  assign w_aluop = i_ex.ex_ctrl_in[EX_ALUOP_HI:EX_ALUOP_LO];
  assign w_funct = i_ex.imm_in[5:0];

  always_comb begin
    w_op      = ALU_ADD;
    w_illegal = 1'b0;
    case (w_aluop)
      ALUOP_SUB: w_op = ALU_SUB;
      ALUOP_RTYPE: begin
        case (w_funct)
          FUNCT_ADD: w_op = ALU_ADD;
          FUNCT_SUB: w_op = ALU_SUB;
          FUNCT_AND: w_op = ALU_AND;
          FUNCT_OR:  w_op = ALU_OR;
          FUNCT_SLT: w_op = ALU_SLT;
          default: begin
            w_op      = ALU_ZERO;
            w_illegal = 1'b1;
          end
        endcase
      end
      default: w_op = ALU_ADD;
    endcase
  end

`ifdef FORWARDING_EN
  logic w_exmem_fwd_ok;
  logic w_wb_fwd_ok;

  // A load in EX/MEM has no data yet, so it never bypasses; r0 is never bypassed.
  assign w_exmem_fwd_ok = r_out_valid & r_wb_ctrl[WB_REGWRITE] & ~r_mem_ctrl[MEM_READ]
                        & (r_write_reg != '0);
  assign w_wb_fwd_ok    = i_ex.wb_reg_write & (i_ex.wb_reg != '0);

  assign w_op_a   = (w_exmem_fwd_ok && (r_write_reg == i_ex.rs_in)) ? r_alu_result :
                    (w_wb_fwd_ok && (i_ex.wb_reg == i_ex.rs_in))   ? i_ex.wb_data :
                    i_ex.read_data1;
  assign w_rt_val = (w_exmem_fwd_ok && (r_write_reg == i_ex.rt_in)) ? r_alu_result :
                    (w_wb_fwd_ok && (i_ex.wb_reg == i_ex.rt_in))   ? i_ex.wb_data :
                    i_ex.read_data2;
`else
  assign w_op_a   = i_ex.read_data1;
  assign w_rt_val = i_ex.read_data2;
`endif

  assign w_op_b   = i_ex.ex_ctrl_in[EX_ALUSRC] ? i_ex.imm_in : w_rt_val;
  assign w_target = i_ex.pc_in + {i_ex.imm_in[WORD_SIZE-3:0], 2'b00};
  assign w_dest   = i_ex.ex_ctrl_in[EX_REGDST] ? i_ex.rd_in : i_ex.rt_in;

  alu_core u_alu (
    .i_op     (w_op),
    .i_a      (w_op_a),
    .i_b      (w_op_b),
    .o_result (w_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid     <= 1'b0;
      r_mem_ctrl      <= '0;
      r_wb_ctrl       <= '0;
      r_alu_result    <= '0;
      r_store_data    <= '0;
      r_branch_target <= '0;
      r_zero          <= 1'b0;
      r_write_reg     <= '0;
      r_illegal       <= 1'b0;
    end else if (i_ex.flush) begin
      r_out_valid <= 1'b0;
      r_mem_ctrl  <= '0;
      r_wb_ctrl   <= '0;
      r_illegal   <= 1'b0;
    end else if (!i_ex.stall) begin
      if (i_ex.in_valid) begin
        r_out_valid     <= 1'b1;
        r_mem_ctrl      <= i_ex.mem_ctrl_in;
        r_wb_ctrl       <= {i_ex.wb_ctrl_in[WB_REGWRITE] & ~w_illegal,
                            i_ex.wb_ctrl_in[WB_MEMTOREG]};
        r_alu_result    <= w_result;
        r_store_data    <= w_rt_val;
        r_branch_target <= w_target;
        r_zero          <= (w_result == '0);
        r_write_reg     <= w_dest;
        r_illegal       <= w_illegal;
      end else begin
        r_out_valid <= 1'b0;
        r_mem_ctrl  <= '0;
        r_wb_ctrl   <= '0;
        r_illegal   <= 1'b0;
      end
    end
  end

  assign i_ex.out_valid     = r_out_valid;
  assign i_ex.mem_ctrl_out  = r_mem_ctrl;
  assign i_ex.wb_ctrl_out   = r_wb_ctrl;
  assign i_ex.alu_result    = r_alu_result;
  assign i_ex.store_data    = r_store_data;
  assign i_ex.branch_target = r_branch_target;
  assign i_ex.zero          = r_zero;
  assign i_ex.write_reg     = r_write_reg;
  assign i_ex.illegal_funct = r_illegal;

endmodule

// File: tb/tb_execute_unit.sv
// Directed bench for execute_unit: each driven slot pushes its expected EX/MEM image,
// which is popped and compared one cycle later.
module tb_execute_unit;
  import pipe_pkg::*;

  logic clk;
  logic rst;

  execute_unit_if bus ();

  execute_unit dut (
    .clk  (clk),
    .rst  (rst),
    .i_ex (bus)
  );

  typedef struct {
    logic        cd;
    logic        vld;
    logic [2:0]  mem;
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [31:0] st;
    logic [31:0] bt;
    logic        zero;
    logic [4:0]  wr;
    logic        ill;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   errors = 0;
  int   checks = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic exp_t mk(input logic cd, input logic vld, input logic [2:0] mem,
                              input logic [1:0] wb, input logic [31:0] alu,
                              input logic [31:0] st, input logic [31:0] bt,
                              input logic zero, input logic [4:0] wr, input logic ill);
    exp_t e;
    e.cd = cd; e.vld = vld; e.mem = mem; e.wb = wb; e.alu = alu;
    e.st = st; e.bt = bt; e.zero = zero; e.wr = wr; e.ill = ill;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] ex, input logic [2:0] mem,
                       input logic [1:0] wb, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] imm, input logic [4:0] rt,
                       input logic [4:0] rd, input exp_t e);
    bus.in_valid = v;    bus.stall = 1'b0;      bus.flush = 1'b0;
    bus.ex_ctrl_in = ex; bus.mem_ctrl_in = mem; bus.wb_ctrl_in = wb;
    bus.pc_in = pc;      bus.read_data1 = a;    bus.read_data2 = b;
    bus.imm_in = imm;    bus.rt_in = rt;        bus.rd_in = rd;
`ifdef FORWARDING_EN
    bus.rs_in = '0; bus.wb_reg_write = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
`endif
    sb.push_back(e);
  endtask

  task automatic step(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".valid"}, {31'b0, bus.out_valid}, {31'b0, e.vld});
      chk({tag, ".mem"}, {29'b0, bus.mem_ctrl_out}, {29'b0, e.mem});
      chk({tag, ".wb"}, {30'b0, bus.wb_ctrl_out}, {30'b0, e.wb});
      chk({tag, ".ill"}, {31'b0, bus.illegal_funct}, {31'b0, e.ill});
      if (e.cd) begin
        chk({tag, ".alu"}, bus.alu_result, e.alu);
        chk({tag, ".st"}, bus.store_data, e.st);
        chk({tag, ".bt"}, bus.branch_target, e.bt);
        chk({tag, ".zero"}, {31'b0, bus.zero}, {31'b0, e.zero});
        chk({tag, ".wr"}, {27'b0, bus.write_reg}, {27'b0, e.wr});
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".valid"}, {31'b0, bus.out_valid}, 32'h0);
    chk({tag, ".mem"}, {29'b0, bus.mem_ctrl_out}, 32'h0);
    chk({tag, ".wb"}, {30'b0, bus.wb_ctrl_out}, 32'h0);
    chk({tag, ".alu"}, bus.alu_result, 32'h0);
    chk({tag, ".st"}, bus.store_data, 32'h0);
    chk({tag, ".bt"}, bus.branch_target, 32'h0);
    chk({tag, ".zero"}, {31'b0, bus.zero}, 32'h0);
    chk({tag, ".wr"}, {27'b0, bus.write_reg}, 32'h0);
    chk({tag, ".ill"}, {31'b0, bus.illegal_funct}, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 4'h0, 3'h0, 2'h0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    void'(sb.pop_front());
    #3;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // R-type add, beq, lw
    drive(1, 4'b1010, 3'b000, 2'b10, 32'h4, 5, 7, 32'h20, 5'd2, 5'd3,
          mk(1, 1, 3'b000, 2'b10, 12, 7, 32'h84, 0, 3, 0));
    step("r_add");
    drive(1, 4'b0001, 3'b001, 2'b00, 32'h100, 32'h1234, 32'h1234, 4, 5'd5, 5'd0,
          mk(1, 1, 3'b001, 2'b00, 0, 32'h1234, 32'h110, 1, 5, 0));
    step("beq");
    drive(1, 4'b0100, 3'b100, 2'b11, 32'h200, 32'h1000, 32'hAA, 32'hFFFFFFFC, 5'd8, 5'd0,
          mk(1, 1, 3'b100, 2'b11, 32'hFFC, 32'hAA, 32'h1F0, 0, 8, 0));
    step("lw");

    // slt (signed), unsupported funct, remaining R-type ops
    drive(1, 4'b1010, 3'b000, 2'b10, 32'h10, 32'hFFFFFFFF, 1, 32'h2A, 5'd1, 5'd9,
          mk(1, 1, 0, 2'b10, 1, 1, 32'hB8, 0, 9, 0));
    step("slt_neg");
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 1, 32'hFFFFFFFF, 32'h2A, 5'd1, 5'd16,
          mk(1, 1, 0, 2'b10, 0, 32'hFFFFFFFF, 32'hA8, 1, 16, 0));
    step("slt_pos");
    drive(1, 4'b1010, 3'b000, 2'b11, 32'h20, 3, 4, 32'h3F, 5'd2, 5'd10,
          mk(1, 1, 0, 2'b01, 0, 4, 32'h11C, 1, 10, 1));
    step("illegal");
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 3, 5, 32'h22, 5'd1, 5'd11,
          mk(1, 1, 0, 2'b10, 32'hFFFFFFFE, 5, 32'h88, 0, 11, 0));
    step("r_sub");
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 32'hF0F0, 32'hFF00, 32'h24, 5'd1, 5'd12,
          mk(1, 1, 0, 2'b10, 32'hF000, 32'hFF00, 32'h90, 0, 12, 0));
    step("r_and");
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 32'hF0F0, 32'h0F0F, 32'h25, 5'd1, 5'd13,
          mk(1, 1, 0, 2'b10, 32'hFFFF, 32'h0F0F, 32'h94, 0, 13, 0));
    step("r_or");
    drive(1, 4'b0111, 3'b000, 2'b10, 0, 10, 32'h77, 5, 5'd14, 5'd0,
          mk(1, 1, 0, 2'b10, 15, 32'h77, 32'h14, 0, 14, 0));
    step("aluop11");
    drive(1, 4'b0000, 3'b000, 2'b10, 0, 32'hFFFFFFFF, 1, 0, 5'd15, 5'd0,
          mk(1, 1, 0, 2'b10, 0, 1, 0, 1, 15, 0));
    step("add_wrap");

    drive(0, 4'b1010, 3'b111, 2'b11, 0, 1, 1, 32'h20, 5'd1, 5'd1,
          mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("bubble");

    // load, stall two cycles with new inputs, then flush while still stalled
    held = mk(1, 1, 3'b010, 2'b10, 32'h33, 32'h22, 32'hC0, 0, 7, 0);
    drive(1, 4'b1010, 3'b010, 2'b10, 32'h40, 32'h11, 32'h22, 32'h20, 5'd6, 5'd7, held);
    step("pre_stall");
    drive(1, 4'b1010, 3'b101, 2'b11, 32'h80, 1, 1, 32'h3F, 5'd9, 5'd9, held);
    bus.stall = 1'b1;
    step("stall1");
    sb.push_back(held);
    step("stall2");
    bus.flush = 1'b1;
    sb.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("flush");

    // asynchronous reset between edges
    drive(1, 4'b1010, 3'b000, 2'b10, 32'h4, 5, 7, 32'h20, 5'd2, 5'd3,
          mk(1, 1, 3'b000, 2'b10, 12, 7, 32'h84, 0, 3, 0));
    step("pre_rst");
    #2;
    rst = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    #1;
    rst = 1'b1;

`ifdef FORWARDING_EN
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 5, 7, 32'h20, 5'd2, 5'd3,
          mk(1, 1, 0, 2'b10, 12, 7, 32'h80, 0, 3, 0));
    bus.rs_in = 5'd1;
    step("fwd_r3");
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 0, 0, 32'h20, 5'd3, 5'd4,
          mk(1, 1, 0, 2'b10, 24, 12, 32'h80, 0, 4, 0));
    bus.rs_in = 5'd3; bus.wb_reg_write = 1'b1; bus.wb_reg = 5'd3; bus.wb_data = 32'h99;
    step("fwd_exmem_wins");
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 0, 1, 32'h20, 5'd5, 5'd6,
          mk(1, 1, 0, 2'b10, 32'h9A, 1, 32'h80, 0, 6, 0));
    bus.rs_in = 5'd3; bus.wb_reg_write = 1'b1; bus.wb_reg = 5'd3; bus.wb_data = 32'h99;
    step("fwd_wb");
    drive(1, 4'b1010, 3'b000, 2'b10, 0, 2, 3, 32'h20, 5'd0, 5'd7,
          mk(1, 1, 0, 2'b10, 5, 3, 32'h80, 0, 7, 0));
    bus.rs_in = 5'd0; bus.wb_reg_write = 1'b1; bus.wb_reg = 5'd0; bus.wb_data = 32'h55;
    step("fwd_r0");
`endif

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: observed=%0d expected=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
